// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request/data inputs and grant/select/data outputs of the 4:1 arbiter.
// No timing of its own; all signals are plain wires between source side and arbiter.
// No flow control here; request level is the only handshake.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  // Requesting sources / consumer side
  modport master (
    output req,
    output i,
    input  gnt,
    input  sel,
    input  busy,
    input  y
  );

  // Arbiter side
  modport slave (
    input  req,
    input  i,
    output gnt,
    output sel,
    output busy,
    output y
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit channel, HOLD_MAX-cycle burst cap.
// Latency: 1 cycle req->gnt/sel/busy; y is combinational from i[sel].
// Backpressure: none; a requester waits by holding req until granted at a release point.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  // Registered state
  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic [CNT_W-1:0] r_hold;
  logic [1:0]       r_last;

  // Next-state values
  state_t           w_state_nxt;
  logic [3:0]       w_gnt_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [1:0]       w_last_nxt;

  // Priority search results
  logic [1:0]       w_start;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic             w_found;
  logic             w_cont;

  // The owner is always r_last while granted, so one search starting after r_last
  // serves both the idle case and the release case; the owner comes up last.
  assign w_start = r_last + 2'd1;

  // Scan requests from w_start upward with wrap-around; first set bit wins
  always_comb begin
    w_found = 1'b0;
    w_win   = w_start;
    w_idx   = w_start;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Owner keeps the channel only while still requesting and under the burst cap
  assign w_cont = bus.req[r_last] && (r_hold < HOLD_LAST);

  // State and grant registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state decision: grant, continue, switch or return to idle
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_last_nxt  = w_win;
        end
      end
      ST_GRANT: begin
        if (w_cont) begin
          w_hold_nxt = r_hold + 1'b1;
        end else if (w_found) begin
          // Direct hand-over, no idle gap; may re-grant the same owner
          w_gnt_nxt  = 4'b0001 << w_win;
          w_sel_nxt  = w_win;
          w_hold_nxt = '0;
          w_last_nxt = w_win;
        end else begin
          // Nobody left: drop grant, sel keeps its last value
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Outputs: registered grant fields plus the unregistered data mux
  always_comb begin
    bus.gnt  = r_gnt;
    bus.sel  = r_sel;
    bus.busy = r_busy;
    bus.y    = r_busy ? bus.i[r_sel] : 1'b0;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with HOLD_MAX=4.
// Inputs change 1ns after each rising edge; outputs are checked there too.
// Each output field comparison counts as one vector.
module tb_mux4_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  mux4_rr_arbiter_if dut_if ();

  mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic ey);
    cmp(tag, "gnt",  dut_if.gnt,          eg);
    cmp(tag, "sel",  {2'b00, dut_if.sel}, {2'b00, es});
    cmp(tag, "busy", {3'b000, dut_if.busy}, {3'b000, eb});
    cmp(tag, "y",    {3'b000, dut_if.y},    {3'b000, ey});
  endtask

  initial begin
    logic [3:0] i_pat;
    logic [1:0] own;
    n_vec = 0;
    n_bad = 0;

    // 1. Reset with all requesting, then first grant to requester 0
    rst_n      = 1'b0;
    dut_if.req = 4'b1111;
    dut_if.i   = 4'b0000;
    step();
    chk("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    i_pat = 4'b1010;
    dut_if.i = i_pat;
    step();
    chk("first", 4'b0001, 2'd0, 1'b1, i_pat[0]);

    // 2. Full rotation: four cycles per owner, no gap, back to 0
    for (int n = 1; n <= 16; n++) begin
      step();
      own = 2'((n / 4) % 4);
      chk($sformatf("rot%0d", n), 4'b0001 << own, own, 1'b1, i_pat[own]);
    end

    // 3. Early release: requester 2 for two cycles, then requester 0
    dut_if.req = 4'b0100;
    dut_if.i   = 4'b0000;
    step();
    chk("early_a", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk("early_b", 4'b0100, 2'd2, 1'b1, 1'b0);
    dut_if.req = 4'b0001;
    step();
    chk("early_c", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 4. Sole requester re-granted across the hold rollover, then idle
    dut_if.req = 4'b0010;
    dut_if.i   = 4'b0010;
    for (int n = 0; n < 10; n++) begin
      step();
      chk($sformatf("sole%0d", n), 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    dut_if.req = 4'b0000;
    step();
    chk("idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // 5. Data routing through sel=2, then y forced low while idle
    dut_if.req = 4'b0100;
    step();
    chk("route_g", 4'b0100, 2'd2, 1'b1, 1'b0);
    dut_if.i = 4'b0100;
    #1;
    chk("route_1", 4'b0100, 2'd2, 1'b1, 1'b1);
    dut_if.i = 4'b1011;
    #1;
    chk("route_0", 4'b0100, 2'd2, 1'b1, 1'b0);
    dut_if.req = 4'b0000;
    step();
    dut_if.i = 4'b1111;
    #1;
    chk("route_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // 6. Asynchronous reset in the middle of requester 3's grant
    dut_if.req = 4'b1000;
    step();
    chk("own3", 4'b1000, 2'd3, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1;
    rst_n      = 1'b1;
    dut_if.req = 4'b1111;
    step();
    chk("post_arst", 4'b0001, 2'd0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
